ad7276_sample_scheduler: RTL
============================

# ad7276_sample_scheduler

Sequencing controller for the dual-channel AD7276 capture engine. It generates the programmable sample-rate tick and issues one conversion request per tick. It collects the two channel results, packs them into one AXI4-Stream beat, and frames the stream with `tlast`. It sits between the AXI-Lite register bank (enable, divider, burst length) and the capture engine / downstream DMA, and reports overruns when the stream back-pressures longer than one sample period.

## Interface

Parameters:
- `ADC_LENGTH`, 12: result width per channel; legal range 1..16.
- `FRAME_LEN`, 256: beats per `tlast` frame in continuous mode; minimum 1.
- `MIN_DIV`, 16: smallest honoured sample divider (clock cycles).

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run request, level-sensitive.
- `sample_div` in 32: clocks per sample. 0 selects 48; 1..MIN_DIV-1 clamp to MIN_DIV.
- `burst_len` in 16: samples per run; 0 = continuous.
- `conv_start` out 1: one-cycle request to the capture engine.
- `conv_done` in 1: one-cycle pulse; `adc_data1/2` valid in the same cycle.
- `adc_data1` in ADC_LENGTH: channel 1 result.
- `adc_data2` in ADC_LENGTH: channel 2 result.
- `m_axis_tdata` out 32: `{zero-pad, adc_data2, zero-pad, adc_data1}`, each channel in a 16-bit lane, LSB-aligned.
- `m_axis_tvalid` out 1: AXIS valid.
- `m_axis_tready` in 1: AXIS ready.
- `m_axis_tlast` out 1: frame / burst end marker.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a burst completes.
- `overrun` out 1: sticky; tick was lost.
- `overrun_clr` in 1: clears `overrun` (and the counter).
- `overrun_count` out 16: lost-tick count; present only with `AD7276_OVERRUN_CNT_EN`.

## Operation

- Reset values: all outputs 0, state IDLE, period counter 0, beat and frame counters 0.
- Period counter:
  - Runs only while state is not IDLE.
  - `tick` is asserted when the count equals `eff_div-1`; the counter then wraps to 0.
  - `eff_div` is latched at leaving IDLE; changes made mid-run are ignored.
- IDLE: on `enable`=1, latch `eff_div` and `burst_len`, clear the counters, go to WAIT_TICK.
- WAIT_TICK:
  - On `tick`, assert `conv_start` on the next cycle and go to CONVERT.
  - If `enable`=0, go to IDLE.
- CONVERT:
  - On `conv_done`, register both results into the output register.
  - Assert `m_axis_tvalid` and go to PUSH.
- PUSH:
  - Hold `tdata`, `tvalid` and `tlast` stable until `tready`.
  - On handshake, increment the beat count.
  - If the burst is complete, pulse `done` and go to IDLE.
  - Otherwise, if `enable`=0, go to IDLE.
  - Otherwise go to WAIT_TICK.
- `tlast` is 1 when the frame count equals `FRAME_LEN-1` (the frame count then wraps), or when the beat is the last of a non-zero burst.
- A `tick` that occurs in CONVERT or PUSH is dropped: set `overrun` and increment `overrun_count`, which saturates at 0xFFFF.
- Simultaneous `overrun_clr` and a new overrun: the set wins, and the counter loads 1.
- `conv_done` outside CONVERT is ignored.
- `enable` deasserted mid-conversion: the current sample still completes and is delivered, then the block returns to IDLE. `done` is not pulsed.
- `rst` mid-operation: immediate return to reset values, with any in-flight beat discarded. An in-flight capture engine conversion completes harmlessly.

## Timing

- `enable` sampled high at cycle E → first `tick` at cycle E+1+`eff_div`-1 → `conv_start` at the following cycle.
- `conv_done` at cycle C → `m_axis_tvalid`=1 at C+1. This one-cycle registered latency is fixed.
- Subsequent ticks are spaced exactly `eff_div` cycles apart, independent of stream stalls.
- `done` is asserted in the cycle after the final handshake. `busy` drops in the same cycle.

## Configuration

- `AD7276_OVERRUN_CNT_EN` defined: the 16-bit saturating `overrun_count` register is built and cleared by `overrun_clr`/`rst`.
- Macro undefined: the counter logic is removed and `overrun_count` is driven constant 0. The sticky `overrun` flag is unaffected.

## Test plan

- `sample_div`=0, `burst_len`=4, `tready`=1, capture model returns `conv_done` 14 cycles after `conv_start` → `conv_start` spacing 48 cycles, 4 beats, `tlast` only on beat 4, one `done` pulse, `busy` low afterward.
- `sample_div`=5 → `eff_div`=16: `conv_start` spacing 16 cycles. Data 0xABC/0x123 → `tdata`=0x01230ABC.
- `FRAME_LEN`=8, continuous, 20 samples, `tready`=1 → `tlast` on beats 8 and 16 only.
- `tready` held low for 3×`eff_div` during beat 2 → `tdata` stable while stalled, `overrun`=1, `overrun_count`=3 (macro on) or 0 (macro off). Pulse `overrun_clr` → both clear.
- `enable` dropped one cycle after `conv_start` → beat still delivered, then IDLE, no `done`, no further `conv_start`.
- `rst` asserted while in PUSH with `tvalid`=1 → next cycle all outputs 0, state IDLE. A late `conv_done` is ignored.

Source files
------------

// File: rtl/ad7276_sample_scheduler.sv
// ad7276_sample_scheduler
// Sample-rate sequencer for the dual-channel AD7276 capture engine: derives
// the sample tick, requests one conversion per tick, packs both channel
// results into a 32-bit AXI4-Stream beat and frames the stream with tlast.
// Optional build macro: AD7276_OVERRUN_CNT_EN adds the 16-bit saturating
// overrun_count register; without it overrun_count is tied to zero.
module ad7276_sample_scheduler #(
  parameter int ADC_LENGTH = 12,
  parameter int FRAME_LEN  = 256,
  parameter int MIN_DIV    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           sample_div,
  input  logic [15:0]           burst_len,
  output logic                  conv_start,
  input  logic                  conv_done,
  input  logic [ADC_LENGTH-1:0] adc_data1,
  input  logic [ADC_LENGTH-1:0] adc_data2,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [15:0]           overrun_count
);

  localparam int FRAME_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CONV = 2'd2,
    S_PUSH = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [31:0]          r_cnt;
  logic [31:0]          r_eff_div;
  logic [15:0]          r_burst;
  logic [15:0]          r_beat_cnt;
  logic [FRAME_W-1:0]   r_frame_cnt;
  logic [31:0]          w_eff_div;
  logic                 w_tick;
  logic                 w_handshake;
  logic                 w_burst_end;
  logic                 w_conv_start_nxt;
  logic                 w_load;
  logic                 w_done_nxt;
  logic                 w_drop;
  logic                 w_tlast_nxt;
  logic                 w_busy_nxt;

  // Effective divider: 0 selects the 48-clock default, small values clamp up
  always_comb begin
    if (sample_div == 32'd0) begin
      w_eff_div = 32'd48;
    end else if (sample_div < 32'(MIN_DIV)) begin
      w_eff_div = 32'(MIN_DIV);
    end else begin
      w_eff_div = sample_div;
    end
  end

  assign w_tick      = (r_state != S_IDLE) && (r_cnt == (r_eff_div - 32'd1));
  assign w_handshake = m_axis_tvalid && m_axis_tready;
  assign w_burst_end = (r_burst != 16'd0) && (r_beat_cnt == (r_burst - 16'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a tick in WAIT takes priority over a dropped enable
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next_state = S_WAIT;
        else        w_next_state = S_IDLE;
      end
      S_WAIT: begin
        if (w_tick)       w_next_state = S_CONV;
        else if (!enable) w_next_state = S_IDLE;
        else              w_next_state = S_WAIT;
      end
      S_CONV: begin
        if (conv_done) w_next_state = S_PUSH;
        else           w_next_state = S_CONV;
      end
      S_PUSH: begin
        if (w_handshake) begin
          if (w_burst_end || !enable) w_next_state = S_IDLE;
          else                        w_next_state = S_WAIT;
        end else begin
          w_next_state = S_PUSH;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs
  always_comb begin
    w_conv_start_nxt = (r_state == S_WAIT) && w_tick;
    w_load           = (r_state == S_CONV) && conv_done;
    w_done_nxt       = (r_state == S_PUSH) && w_handshake && w_burst_end;
    w_drop           = w_tick && ((r_state == S_CONV) || (r_state == S_PUSH));
    w_tlast_nxt      = (r_frame_cnt == FRAME_LAST) || w_burst_end;
    w_busy_nxt       = (w_next_state != S_IDLE);
  end

  // Period counter, run latches, beat/frame counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= 32'd0;
      r_eff_div     <= 32'd0;
      r_burst       <= 16'd0;
      r_beat_cnt    <= 16'd0;
      r_frame_cnt   <= '0;
      conv_start    <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= 32'd0;
    end else begin
      conv_start <= w_conv_start_nxt;
      done       <= w_done_nxt;
      busy       <= w_busy_nxt;
      if (r_state == S_IDLE) begin
        r_cnt <= 32'd0;
        if (enable) begin
          r_eff_div   <= w_eff_div;
          r_burst     <= burst_len;
          r_beat_cnt  <= 16'd0;
          r_frame_cnt <= '0;
        end
      end else if (w_tick) begin
        r_cnt <= 32'd0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= w_tlast_nxt;
        m_axis_tdata  <= {16'(adc_data2), 16'(adc_data1)};
      end else if (w_handshake) begin
        m_axis_tvalid <= 1'b0;
        r_beat_cnt    <= r_beat_cnt + 16'd1;
        if (r_frame_cnt == FRAME_LAST) r_frame_cnt <= '0;
        else                           r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
      if (w_drop)           overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

`ifdef AD7276_OVERRUN_CNT_EN
  logic [15:0] r_ovr_cnt;

  // Saturating lost-tick counter; a coincident clear and drop loads 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr_cnt <= 16'd0;
    end else if (w_drop) begin
      if (overrun_clr)               r_ovr_cnt <= 16'd1;
      else if (r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 16'd1;
    end else if (overrun_clr) begin
      r_ovr_cnt <= 16'd0;
    end
  end

  assign overrun_count = r_ovr_cnt;
`else
  assign overrun_count = 16'd0;
`endif

endmodule
